alu_seq: RTL and testbench

Sequencing controller placed in front of the `alu` datapath. Accepts one operation request at a time, latches the operands, and drives the ALU operand and opcode inputs. For multiply it pulses the multiplier start (`init`) and waits for `done`, with a timeout. It captures the 6-bit result and flags and holds them under a valid/ack handshake until the consumer (display or host logic) takes them.

---
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencing controller in front of the alu datapath: latches one request, drives the
// ALU operand/opcode registers, runs the multiplier start/done handshake with a timeout,
// and holds the captured result under a valid/ack handshake.
module alu_seq #(
    parameter int SETTLE      = 1,
    parameter int MUL_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op_in,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       sel_in,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ack,
    output logic [5:0] res,
    output logic [2:0] res_flags,
    output logic       err,
    output logic [3:0] alu_A,
    output logic [3:0] alu_B,
    output logic [1:0] alu_OP,
    output logic       alu_sel,
    output logic       alu_init,
    input  logic [5:0] alu_resul,
    input  logic       alu_done,
    input  logic       alu_signo,
    input  logic       alu_cout,
    input  logic       alu_cout_s
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EXEC,
        MUL_START,
        MUL_WAIT,
        HOLD
    } state_t;

    localparam logic [1:0] OP_MUL      = 2'b10;
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);
    localparam logic [7:0] TMO_LAST    = 8'(MUL_TIMEOUT - 1);

    state_t     state_reg, state_next;

    // A request is staged for one cycle before it is loaded into the ALU registers.
    logic       req_valid_reg;
    logic [1:0] req_op_reg;
    logic [3:0] req_a_reg;
    logic [3:0] req_b_reg;
    logic       req_sel_reg;
    logic       req_take;

    logic [3:0] alu_a_reg;
    logic [3:0] alu_b_reg;
    logic [1:0] alu_op_reg;
    logic       alu_sel_reg;

    logic [3:0] settle_cnt_reg;
    logic [7:0] tmo_cnt_reg;

    logic [5:0] res_reg;
    logic [2:0] flags_reg;
    logic       err_reg;

    logic       load_ops;
    logic       load_settle;
    logic       dec_settle;
    logic       clr_tmo;
    logic       inc_tmo;
    logic       cap_res;
    logic       cap_err;

    assign req_take = start && (state_reg == IDLE) && !req_valid_reg;

    always_comb begin
        state_next  = state_reg;
        load_ops    = 1'b0;
        load_settle = 1'b0;
        dec_settle  = 1'b0;
        clr_tmo     = 1'b0;
        inc_tmo     = 1'b0;
        cap_res     = 1'b0;
        cap_err     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid_reg) begin
                    load_ops   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (alu_op_reg == OP_MUL) begin
                    state_next = MUL_START;
                end else begin
                    load_settle = 1'b1;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                if (settle_cnt_reg == 4'd1) begin
                    cap_res    = 1'b1;
                    state_next = HOLD;
                end else begin
                    dec_settle = 1'b1;
                end
            end
            MUL_START: begin
                clr_tmo    = 1'b1;
                state_next = MUL_WAIT;
            end
            MUL_WAIT: begin
                // A zero count marks the first wait cycle, where a stale done is ignored.
                if ((tmo_cnt_reg != 8'd0) && alu_done) begin
                    cap_res    = 1'b1;
                    state_next = HOLD;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    cap_err    = 1'b1;
                    state_next = HOLD;
                end else begin
                    inc_tmo = 1'b1;
                end
            end
            HOLD: begin
                if (res_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            req_valid_reg  <= 1'b0;
            req_op_reg     <= 2'b00;
            req_a_reg      <= 4'd0;
            req_b_reg      <= 4'd0;
            req_sel_reg    <= 1'b0;
            alu_a_reg      <= 4'd0;
            alu_b_reg      <= 4'd0;
            alu_op_reg     <= 2'b00;
            alu_sel_reg    <= 1'b0;
            settle_cnt_reg <= 4'd0;
            tmo_cnt_reg    <= 8'd0;
            res_reg        <= 6'd0;
            flags_reg      <= 3'd0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (req_take) begin
                req_valid_reg <= 1'b1;
                req_op_reg    <= op_in;
                req_a_reg     <= a_in;
                req_b_reg     <= b_in;
                req_sel_reg   <= sel_in;
            end else if (load_ops) begin
                req_valid_reg <= 1'b0;
            end

            if (load_ops) begin
                alu_a_reg   <= req_a_reg;
                alu_b_reg   <= req_b_reg;
                alu_op_reg  <= req_op_reg;
                alu_sel_reg <= req_sel_reg;
            end

            if (load_settle) begin
                settle_cnt_reg <= SETTLE_INIT;
            end else if (dec_settle) begin
                settle_cnt_reg <= settle_cnt_reg - 4'd1;
            end

            if (clr_tmo) begin
                tmo_cnt_reg <= 8'd0;
            end else if (inc_tmo) begin
                tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
            end

            if (cap_res) begin
                res_reg   <= alu_resul;
                flags_reg <= {alu_signo, alu_cout, alu_cout_s};
                err_reg   <= 1'b0;
            end else if (cap_err) begin
                res_reg   <= 6'd0;
                flags_reg <= 3'd0;
                err_reg   <= 1'b1;
            end
        end
    end

    assign busy      = (state_reg != IDLE);
    assign res_valid = (state_reg == HOLD);
    assign alu_init  = (state_reg == MUL_START);
    assign res       = res_reg;
    assign res_flags = flags_reg;
    assign err       = err_reg;
    assign alu_A     = alu_a_reg;
    assign alu_B     = alu_b_reg;
    assign alu_OP    = alu_op_reg;
    assign alu_sel   = alu_sel_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq: the bench plays the ALU, predicts each result,
// its capture edge and multiplier-start count, and a monitor checks every res_valid.
module tb_alu_seq;

    localparam int SETTLE      = 1;
    localparam int MUL_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op_in;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       sel_in;
    logic       busy;
    logic       res_valid;
    logic       res_ack;
    logic [5:0] res;
    logic [2:0] res_flags;
    logic       err;
    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic [1:0] alu_OP;
    logic       alu_sel;
    logic       alu_init;
    logic [5:0] alu_resul;
    logic       alu_done;
    logic       alu_signo;
    logic       alu_cout;
    logic       alu_cout_s;

    alu_seq #(.SETTLE(SETTLE), .MUL_TIMEOUT(MUL_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_in     (op_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .sel_in    (sel_in),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ack   (res_ack),
        .res       (res),
        .res_flags (res_flags),
        .err       (err),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_OP    (alu_OP),
        .alu_sel   (alu_sel),
        .alu_init  (alu_init),
        .alu_resul (alu_resul),
        .alu_done  (alu_done),
        .alu_signo (alu_signo),
        .alu_cout  (alu_cout),
        .alu_cout_s(alu_cout_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // ALU behaviour the bench presents: {signo, cout, cout_s, resul}
    function automatic logic [8:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic sel);
        int s;
        logic [8:0] r;
        r = 9'd0;
        case (op)
            2'b00: begin
                s = int'(a) + int'(b);
                r = {1'b0, s >= 16, 1'b0, 6'(s)};
            end
            2'b01: begin
                if (sel && (a < b)) r = {1'b1, 1'b0, 1'b0, 6'(int'(b) - int'(a))};
                else                r = {1'b0, 1'b0, a >= b, 6'((int'(a) - int'(b)) & 15)};
            end
            2'b10: r = {3'b000, 6'(int'(a[2:0]) * int'(b[2:0]))};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        {alu_signo, alu_cout, alu_cout_s, alu_resul} = alu_ref(alu_OP, alu_A, alu_B, alu_sel);
    end

    // Multiplier model: done pulses for one cycle, D cycles after the init cycle (0 = never)
    int done_delay  = 0;
    int done_at     = -1;
    int init_total  = 0;
    int last_init   = -1;
    always @(negedge clk) begin
        alu_done = (cyc == done_at);
        if (alu_init) begin
            init_total++;
            last_init = cyc;
            done_at   = (done_delay > 0) ? cyc + done_delay : -1;
        end
    end

    typedef struct {
        logic [5:0] res;
        logic [2:0] flags;
        logic       err;
        int         edge_n;
        int         n;
        bit         is_mul;
        int         init_base;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic sel, input int d, input int n);
        exp_t e;
        logic [8:0] r;
        r = alu_ref(op, a, b, sel);
        e.n         = n;
        e.is_mul    = (op == 2'b10);
        e.init_base = init_total;
        e.err       = 1'b0;
        e.res       = r[5:0];
        e.flags     = r[8:6];
        if (op != 2'b10) begin
            e.edge_n = n + 2 + SETTLE;
        end else if (d == 0) begin
            e.res    = 6'd0;
            e.flags  = 3'd0;
            e.err    = 1'b1;
            e.edge_n = n + 3 + MUL_TIMEOUT;
        end else begin
            e.edge_n = n + 3 + d;
        end
        sb.push_back(e);
    endtask

    // Monitor: one comparison set per rising res_valid
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (res_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res", int'(res), int'(e.res));
                chk("res_flags", int'(res_flags), int'(e.flags));
                chk("err", int'(err), int'(e.err));
                chk("capture_edge", cyc, e.edge_n);
                chk("init_pulses", init_total - e.init_base, e.is_mul ? 1 : 0);
                if (e.is_mul) chk("init_edge", last_init, e.n + 2);
                $display("txn n=%0d res=%b flags=%b err=%0d edge=%0d", e.n, res, res_flags, err, cyc);
            end
        end
        prev_valid = res_valid;
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic sel, input int d);
        @(negedge clk);
        op_in = op; a_in = a; b_in = b; sel_in = sel; start = 1'b1; done_delay = d;
        push_exp(op, a, b, sel, d, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_setup", int'(busy), 1);
        chk("alu_regs", int'({alu_OP, alu_sel, alu_A, alu_B}), int'({op, sel, a, b}));
    endtask

    task automatic finish_txn();
        int n;
        int hold;
        logic [9:0] snap;
        n = 0;
        while (!res_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            chk("valid_timeout", 0, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
        end else begin
            snap = {res, res_flags, err};
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) begin
                if (i == 0) begin
                    start = 1'b1;
                    op_in = 2'($urandom_range(0, 3));
                    a_in  = 4'($urandom_range(0, 15));
                end
                @(negedge clk);
                start = 1'b0;
                chk("hold_stable", int'({res_valid, res, res_flags, err}), int'({1'b1, snap}));
            end
            res_ack = 1'b1;
            start   = 1'($urandom_range(0, 1));
            @(negedge clk);
            res_ack = 1'b0;
            start   = 1'b0;
            chk("ack_release", int'({res_valid, busy}), 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op_in = 2'b00; a_in = 4'd2; b_in = 4'd3;
        sel_in = 1'b0; res_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", int'({busy, res_valid, err, alu_init, res, res_flags,
                                       alu_A, alu_B, alu_OP, alu_sel}), 0);
        end
        rst = 1'b0;
        push_exp(2'b00, 4'd2, 4'd3, 1'b0, 0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        finish_txn();

        issue(2'b00, 4'd7, 4'd5, 1'b0, 0); finish_txn();
        issue(2'b01, 4'd3, 4'd6, 1'b1, 0); finish_txn();
        issue(2'b10, 4'd6, 4'd7, 1'b0, 4); finish_txn();
        issue(2'b10, 4'd6, 4'd7, 1'b0, 0); finish_txn();
        issue(2'b00, 4'd9, 4'd8, 1'b0, 0); finish_txn();
        issue(2'b10, 4'd15, 4'd11, 1'b0, MUL_TIMEOUT); finish_txn();
        issue(2'b10, 4'd13, 4'd10, 1'b0, 2); finish_txn();
        issue(2'b11, 4'd5, 4'd5, 1'b0, 0); finish_txn();

        // reset in the middle of a multiply wait
        issue(2'b10, 4'd5, 4'd3, 1'b0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("reset_abort", int'({busy, res_valid, alu_init}), 0);
        issue(2'b00, 4'd4, 4'd1, 1'b0, 0); finish_txn();

        for (int t = 0; t < 30; t++) begin
            logic [1:0] op;
            int d;
            op = 2'($urandom_range(0, 3));
            d  = 0;
            if (op == 2'b10) d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, MUL_TIMEOUT);
            issue(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), d);
            finish_txn();
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
